// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit and its MDU scoreboard.
package hazard_pkg;

  // Forwarding select codes (D stage uses all four, E stage uses RF/W/M).
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  // Result-source codes carried by the E and M pipeline registers.
  localparam logic [1:0] REGSRC_ALU  = 2'd0;
  localparam logic [1:0] REGSRC_LOAD = 2'd1;
  localparam logic [1:0] REGSRC_LINK = 2'd2;

  // Width of the MDU latency down-counter; covers latencies up to 15.
  localparam int MDU_CNT_W = 4;

endpackage

// File: rtl/mdu_scoreboard.sv
// Tracks the single outstanding MDU register write: counts down from issue
// to the write slot and remembers the destination register.
module mdu_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int MDU_LAT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mdu_startE,
  input  logic          kill,
  input  logic [AW-1:0] WAddrE,
  output logic          mdu_busy,
  output logic          mdu_wb,
  output logic [AW-1:0] mdu_waddr
);

  logic [MDU_CNT_W-1:0] cnt;

  // Latency counter and destination: kill beats a new issue, and a start
  // that arrives while a write is still outstanding is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      mdu_waddr <= '0;
    end else if (kill) begin
      cnt <= '0;
    end else if (mdu_startE && (cnt == '0)) begin
      cnt       <= MDU_CNT_W'(MDU_LAT);
      mdu_waddr <= WAddrE;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign mdu_busy = (cnt != '0);
  assign mdu_wb   = (cnt == MDU_CNT_W'(1));

  // A second issue while busy should be impossible because D is held by
  // the structural stall; flag it if the surrounding control ever does it.
  startWhileBusy : assert property (@(posedge clk) disable iff (rst)
                                    !(mdu_startE && !kill && (cnt != '0)));

endmodule

// File: rtl/hazard_sb.sv
// Hazard detection and forwarding for the 5-stage pipeline, with an MDU
// write scoreboard and a saturating stall-cycle counter.
module hazard_sb
  import hazard_pkg::*;
#(
  parameter int AW      = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    RAddr1D,
  input  logic [AW-1:0]    RAddr2D,
  input  logic             useRsD,
  input  logic             useRtD,
  input  logic             npc_selD,
  input  logic             jumpD,
  input  logic             mduD,
  input  logic [AW-1:0]    WAddrE,
  input  logic [AW-1:0]    WAddrM,
  input  logic [AW-1:0]    WAddrW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic [1:0]       regsrcE,
  input  logic [1:0]       regsrcM,
  input  logic [AW-1:0]    RAddr1E,
  input  logic [AW-1:0]    RAddr2E,
  input  logic [AW-1:0]    RAddr2M,
  input  logic             mdu_startE,
  input  logic             kill,
  output logic             stall,
  output logic             flushE,
  output logic [2:0]       stall_cause,
  output logic             mdu_busy,
  output logic             mdu_wb,
  output logic [AW-1:0]    mdu_waddr,
  output logic [1:0]       ForwardrsD,
  output logic [1:0]       ForwardrtD,
  output logic [1:0]       ForwardrsE,
  output logic [1:0]       ForwardrtE,
  output logic             ForwardrtM,
  output logic [CNT_W-1:0] stall_cnt
);

  // True when a source register is produced by a writer; $0 never matches.
  function automatic logic hit(input logic [AW-1:0] src,
                               input logic [AW-1:0] dst,
                               input logic          we);
    return we && (dst != '0) && (src == dst);
  endfunction

  logic loadStall;
  logic brStall;
  logic jrStall;
  logic mduStall;
  logic eAluRs;
  logic eAluRt;
  logic mLoadRs;
  logic mLoadRt;

  mdu_scoreboard #(
    .AW      (AW),
    .MDU_LAT (MDU_LAT)
  ) uScoreboard (
    .clk        (clk),
    .rst        (rst),
    .mdu_startE (mdu_startE),
    .kill       (kill),
    .WAddrE     (WAddrE),
    .mdu_busy   (mdu_busy),
    .mdu_wb     (mdu_wb),
    .mdu_waddr  (mdu_waddr)
  );

  // D-stage forwarding (branch compare / jr target): youngest producer wins.
  always_comb begin
    ForwardrsD = FWD_RF;
    if (hit(RAddr1D, WAddrE, regwriteE))      ForwardrsD = FWD_E;
    else if (hit(RAddr1D, WAddrM, regwriteM)) ForwardrsD = FWD_M;
    else if (hit(RAddr1D, WAddrW, regwriteW)) ForwardrsD = FWD_W;

    ForwardrtD = FWD_RF;
    if (hit(RAddr2D, WAddrE, regwriteE))      ForwardrtD = FWD_E;
    else if (hit(RAddr2D, WAddrM, regwriteM)) ForwardrtD = FWD_M;
    else if (hit(RAddr2D, WAddrW, regwriteW)) ForwardrtD = FWD_W;
  end

  // E-stage ALU operand forwarding and M-stage store-data forwarding.
  always_comb begin
    ForwardrsE = FWD_RF;
    if (hit(RAddr1E, WAddrM, regwriteM))      ForwardrsE = FWD_M;
    else if (hit(RAddr1E, WAddrW, regwriteW)) ForwardrsE = FWD_W;

    ForwardrtE = FWD_RF;
    if (hit(RAddr2E, WAddrM, regwriteM))      ForwardrtE = FWD_M;
    else if (hit(RAddr2E, WAddrW, regwriteW)) ForwardrtE = FWD_W;

    ForwardrtM = hit(RAddr2M, WAddrW, regwriteW);
  end

  // Stall causes. Branch/jr compare in D, so a value still being computed
  // in E (other than a link address, which is known in D) or loaded in M
  // cannot be forwarded in time.
  always_comb begin
    loadStall = (regsrcE == REGSRC_LOAD) && (WAddrE != '0) &&
                ((useRsD && (RAddr1D == WAddrE)) ||
                 (useRtD && (RAddr2D == WAddrE)));

    eAluRs  = hit(RAddr1D, WAddrE, regwriteE) && (regsrcE != REGSRC_LINK);
    eAluRt  = hit(RAddr2D, WAddrE, regwriteE) && (regsrcE != REGSRC_LINK);
    mLoadRs = hit(RAddr1D, WAddrM, regwriteM) && (regsrcM == REGSRC_LOAD);
    mLoadRt = hit(RAddr2D, WAddrM, regwriteM) && (regsrcM == REGSRC_LOAD);

    brStall = npc_selD && (eAluRs || eAluRt || mLoadRs || mLoadRt);
    jrStall = jumpD && (eAluRs || mLoadRs);

    // Data dependency on the pending MDU result, or a second MDU op that
    // would need the single busy unit.
    mduStall = mdu_busy &&
               (hit(RAddr1D, mdu_waddr, useRsD) ||
                hit(RAddr2D, mdu_waddr, useRtD) ||
                mduD);

    stall       = loadStall || brStall || jrStall || mduStall;
    flushE      = stall;
    stall_cause = {mduStall, brStall || jrStall, loadStall};
  end

  // Performance counter of stalled cycles, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench for hazard_sb: expected values are queued as each step is
// driven and popped when the corresponding DUT output is sampled.
module tb_hazard_sb;
  import hazard_pkg::*;

  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] RAddr1D, RAddr2D, WAddrE, WAddrM, WAddrW, RAddr1E, RAddr2E, RAddr2M;
  logic useRsD, useRtD, npc_selD, jumpD, mduD;
  logic regwriteE, regwriteM, regwriteW, mdu_startE, kill;
  logic [1:0] regsrcE, regsrcM;

  logic stall, flushE, mdu_busy, mdu_wb, ForwardrtM;
  logic [2:0] stall_cause;
  logic [AW-1:0] mdu_waddr;
  logic [1:0] ForwardrsD, ForwardrtD, ForwardrsE, ForwardrtE;
  logic [15:0] stall_cnt;

  logic stall3, flushE3, mdu_busy3, mdu_wb3, ForwardrtM3;
  logic [2:0] stall_cause3;
  logic [AW-1:0] mdu_waddr3;
  logic [1:0] ForwardrsD3, ForwardrtD3, ForwardrsE3, ForwardrtE3;
  logic [2:0] stall_cnt3;

  hazard_sb #(.AW(AW), .MDU_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .RAddr1D(RAddr1D), .RAddr2D(RAddr2D), .useRsD(useRsD),
    .useRtD(useRtD), .npc_selD(npc_selD), .jumpD(jumpD), .mduD(mduD),
    .WAddrE(WAddrE), .WAddrM(WAddrM), .WAddrW(WAddrW), .regwriteE(regwriteE),
    .regwriteM(regwriteM), .regwriteW(regwriteW), .regsrcE(regsrcE), .regsrcM(regsrcM),
    .RAddr1E(RAddr1E), .RAddr2E(RAddr2E), .RAddr2M(RAddr2M), .mdu_startE(mdu_startE),
    .kill(kill), .stall(stall), .flushE(flushE), .stall_cause(stall_cause),
    .mdu_busy(mdu_busy), .mdu_wb(mdu_wb), .mdu_waddr(mdu_waddr),
    .ForwardrsD(ForwardrsD), .ForwardrtD(ForwardrtD), .ForwardrsE(ForwardrsE),
    .ForwardrtE(ForwardrtE), .ForwardrtM(ForwardrtM), .stall_cnt(stall_cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  hazard_sb #(.AW(AW), .MDU_LAT(4), .CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .RAddr1D(RAddr1D), .RAddr2D(RAddr2D), .useRsD(useRsD),
    .useRtD(useRtD), .npc_selD(npc_selD), .jumpD(jumpD), .mduD(mduD),
    .WAddrE(WAddrE), .WAddrM(WAddrM), .WAddrW(WAddrW), .regwriteE(regwriteE),
    .regwriteM(regwriteM), .regwriteW(regwriteW), .regsrcE(regsrcE), .regsrcM(regsrcM),
    .RAddr1E(RAddr1E), .RAddr2E(RAddr2E), .RAddr2M(RAddr2M), .mdu_startE(mdu_startE),
    .kill(kill), .stall(stall3), .flushE(flushE3), .stall_cause(stall_cause3),
    .mdu_busy(mdu_busy3), .mdu_wb(mdu_wb3), .mdu_waddr(mdu_waddr3),
    .ForwardrsD(ForwardrsD3), .ForwardrtD(ForwardrtD3), .ForwardrsE(ForwardrsE3),
    .ForwardrtE(ForwardrtE3), .ForwardrtM(ForwardrtM3), .stall_cnt(stall_cnt3)
  );

  logic [31:0] expQ[$];
  int tests = 0;
  int fails = 0;
  logic expStall = 1'b0;
  int modelCnt = 0;

  // Reference stall counter: counts the edges at which a stall is expected.
  always @(posedge clk or posedge rst) begin
    if (rst) modelCnt = 0;
    else if (expStall) modelCnt = modelCnt + 1;
  end

  task automatic push(input logic [31:0] v);
    expQ.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] expv;
    tests++;
    if (expQ.size() == 0) begin
      fails++;
      $display("FAIL %s: observed=%0h but no expected value queued", tag, obs);
      return;
    end
    expv = expQ.pop_front();
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task clearIn();
    RAddr1D = '0; RAddr2D = '0; useRsD = 0; useRtD = 0; npc_selD = 0; jumpD = 0; mduD = 0;
    WAddrE = '0; WAddrM = '0; WAddrW = '0; regwriteE = 0; regwriteM = 0; regwriteW = 0;
    regsrcE = REGSRC_ALU; regsrcM = REGSRC_ALU; RAddr1E = '0; RAddr2E = '0; RAddr2M = '0;
    mdu_startE = 0; kill = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clearIn();
    rst = 1'b1;
    #12;
    push(0); chk("rst_busy", mdu_busy);
    push(0); chk("rst_wb", mdu_wb);
    push(0); chk("rst_waddr", mdu_waddr);
    push(0); chk("rst_stall_cnt", stall_cnt);
    push(0); chk("rst_stall", stall);
    rst = 1'b0;

    // 1: load-use stall, then W forwarding into E
    step(); clearIn();
    RAddr1D = 3; useRsD = 1; regsrcE = REGSRC_LOAD; WAddrE = 3; regwriteE = 1; expStall = 1;
    #1;
    push(1); chk("ld_stall", stall);
    push(1); chk("ld_flushE", flushE);
    push(3'b001); chk("ld_cause", stall_cause);
    step(); clearIn();
    RAddr1D = 3; useRsD = 1; WAddrM = 3; regwriteM = 1; regsrcM = REGSRC_LOAD; expStall = 0;
    #1;
    push(0); chk("ld_bubble_stall", stall);
    push(FWD_M); chk("ld_fwdrsD_M", ForwardrsD);
    step(); clearIn();
    RAddr1E = 3; RAddr2M = 3; WAddrW = 3; regwriteW = 1;
    #1;
    push(FWD_W); chk("ld_fwdrsE_W", ForwardrsE);
    push(FWD_RF); chk("ld_fwdrtE_rf", ForwardrtE);
    push(1); chk("st_fwdrtM", ForwardrtM);

    // 2: branch with ALU result in M forwards; with a load in M it stalls
    step(); clearIn();
    WAddrM = 5; regwriteM = 1; regsrcM = REGSRC_ALU; npc_selD = 1; RAddr1D = 5; useRsD = 1;
    #1;
    push(0); chk("br_alu_stall", stall);
    push(FWD_M); chk("br_fwdrsD_M", ForwardrsD);
    regsrcM = REGSRC_LOAD; expStall = 1;
    #1;
    push(1); chk("br_load_stall", stall);
    push(3'b010); chk("br_load_cause", stall_cause);

    // jr: link result in E forwards from E; ALU result in E stalls
    step(); clearIn(); expStall = 0;
    regwriteE = 1; WAddrE = 5; regsrcE = REGSRC_LINK; regwriteM = 1; WAddrM = 5;
    regwriteW = 1; WAddrW = 5; jumpD = 1; RAddr1D = 5; useRsD = 1;
    #1;
    push(0); chk("jr_link_stall", stall);
    push(FWD_E); chk("jr_fwdrsD_E", ForwardrsD);
    regsrcE = REGSRC_ALU; expStall = 1;
    #1;
    push(1); chk("jr_alu_stall", stall);
    push(3'b010); chk("jr_alu_cause", stall_cause);

    // 3: MDU dependency, latency 4
    step(); clearIn(); expStall = 0;
    mdu_startE = 1; WAddrE = 8; RAddr1D = 8; useRsD = 1;
    #1;
    push(0); chk("mdu_issue_stall", stall);
    push(0); chk("mdu_issue_busy", mdu_busy);
    for (int k = 1; k <= 4; k++) begin
      step(); mdu_startE = 0; WAddrE = 0; expStall = 1;
      #1;
      push(1); chk($sformatf("mdu_c%0d_stall", k), stall);
      push(3'b100); chk($sformatf("mdu_c%0d_cause", k), stall_cause);
      push(1); chk($sformatf("mdu_c%0d_busy", k), mdu_busy);
      push(8); chk($sformatf("mdu_c%0d_waddr", k), mdu_waddr);
      push((k == 4) ? 1 : 0); chk($sformatf("mdu_c%0d_wb", k), mdu_wb);
    end
    step(); expStall = 0;
    #1;
    push(0); chk("mdu_release_stall", stall);
    push(0); chk("mdu_release_busy", mdu_busy);
    push(0); chk("mdu_release_wb", mdu_wb);
    push(modelCnt); chk("mdu_stall_cnt", stall_cnt);

    // 4: structural stall for a second MDU op; independent ALU op proceeds
    step(); clearIn(); mdu_startE = 1; WAddrE = 9;
    #1;
    step(); mdu_startE = 0; WAddrE = 0; mduD = 1; RAddr1D = 2; RAddr2D = 4;
    useRsD = 1; useRtD = 1; expStall = 1;
    #1;
    push(1); chk("mdu_struct_stall", stall);
    push(3'b100); chk("mdu_struct_cause", stall_cause);
    step(); mduD = 0; expStall = 0;
    #1;
    push(0); chk("mdu_indep_stall", stall);
    push(1); chk("mdu_indep_busy", mdu_busy);
    repeat (3) step();
    push(0); chk("mdu4_done_busy", mdu_busy);

    // 5: kill mid-op cancels the write
    step(); clearIn(); mdu_startE = 1; WAddrE = 10;
    #1;
    step(); mdu_startE = 0; WAddrE = 0;
    #1;
    push(1); chk("kill_c1_busy", mdu_busy);
    step(); kill = 1;
    #1;
    push(1); chk("kill_c2_busy", mdu_busy);
    step(); kill = 0;
    #1;
    push(0); chk("kill_c3_busy", mdu_busy);
    for (int k = 0; k < 4; k++) begin
      push(0); chk($sformatf("kill_nowb_%0d", k), mdu_wb);
      step();
    end
    // kill and start together: kill wins
    kill = 1; mdu_startE = 1; WAddrE = 12;
    #1;
    step(); kill = 0; mdu_startE = 0; WAddrE = 0;
    #1;
    push(0); chk("kill_beats_start", mdu_busy);

    // async reset mid-op
    step(); mdu_startE = 1; WAddrE = 11;
    #1;
    step(); mdu_startE = 0; WAddrE = 0;
    #1;
    push(1); chk("rstmid_busy_before", mdu_busy);
    push(11); chk("rstmid_waddr_before", mdu_waddr);
    #2 rst = 1;
    #1;
    push(0); chk("rstmid_busy", mdu_busy);
    push(0); chk("rstmid_waddr", mdu_waddr);
    push(0); chk("rstmid_stall_cnt", stall_cnt);
    push(0); chk("rstmid_stall_cnt3", stall_cnt3);
    step(); rst = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      push(0); chk($sformatf("rstmid_nowb_%0d", k), mdu_wb);
    end

    // 6: register 0 never forwards or stalls
    clearIn();
    regwriteE = 1; regwriteM = 1; regwriteW = 1; regsrcE = REGSRC_LOAD; regsrcM = REGSRC_LOAD;
    npc_selD = 1; jumpD = 1; useRsD = 1; useRtD = 1;
    #1;
    push(FWD_RF); chk("zero_fwdrsD", ForwardrsD);
    push(FWD_RF); chk("zero_fwdrtD", ForwardrtD);
    push(FWD_RF); chk("zero_fwdrsE", ForwardrsE);
    push(FWD_RF); chk("zero_fwdrtE", ForwardrtE);
    push(0); chk("zero_fwdrtM", ForwardrtM);
    push(0); chk("zero_stall", stall);

    // saturation of the 3-bit counter under a long load-use stall
    step(); clearIn();
    RAddr2D = 6; useRtD = 1; regsrcE = REGSRC_LOAD; WAddrE = 6; regwriteE = 1; expStall = 1;
    repeat (10) step();
    clearIn(); expStall = 0;
    #1;
    push(0); chk("sat_stall_off", stall);
    push((modelCnt > 7) ? 7 : modelCnt); chk("sat_stall_cnt3", stall_cnt3);
    push(modelCnt); chk("sat_stall_cnt16", stall_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
